pc_fetch_gen: RTL



---
 rtl/pc_fetch_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: next-PC generator for the instruction-fetch stage.
// It issues fetch groups of 1, 2 or 4 words to instruction memory with a
// valid/ready handshake. It handles exception and branch redirects, and it
// holds a branch that arrives during a stall until the stall clears.
// Misaligned PCs are flagged on addr_err and are never fetched.
module pc_fetch_gen #(
    parameter int                 ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = 32'hbfc00000,
    parameter int                 FETCH_WIDTH = 1,
    parameter int                 BOOT_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic                               except,
    input  logic [ADDR_W-1:0]                  except_addr,
    input  logic                               branch,
    input  logic [ADDR_W-1:0]                  branch_addr,
    input  logic                               fetch_ready,
    output logic                               fetch_valid,
    output logic [ADDR_W-1:0]                  pc_addr,
    output logic [$clog2(FETCH_WIDTH):0]       fetch_cnt,
    output logic                               addr_err,
    output logic                               redirect_pending
);

    localparam int                OFF_W     = $clog2(FETCH_WIDTH);
    localparam int                CNT_W     = OFF_W + 1;
    // Byte size of one fetch group, and the mask of the byte-offset bits inside a group.
    localparam logic [ADDR_W-1:0] GRP_BYTES = ADDR_W'(4 * FETCH_WIDTH);
    localparam logic [ADDR_W-1:0] GRP_MASK  = ADDR_W'(4 * FETCH_WIDTH - 1);
    // Mask of the word index inside a group; all zero when a group is one word.
    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(FETCH_WIDTH - 1);
    localparam logic [3:0]        BOOT_LAST = (BOOT_CYCLES == 0) ? 4'd0 : 4'(BOOT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state_q;
    logic [3:0]          boot_cnt_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic                pend_v_q;
    logic                pend_v_d;
    logic [ADDR_W-1:0]   pend_a_q;
    logic [ADDR_W-1:0]   pend_a_d;
    logic                err_s;
    logic                valid_s;
    logic                fire_s;
    logic [CNT_W-1:0]    off_s;

    // Start of the next aligned group. The addition wraps at the top of the address space.
    function automatic logic [ADDR_W-1:0] next_group(input logic [ADDR_W-1:0] pc);
        return (pc & ~GRP_MASK) + GRP_BYTES;
    endfunction

    // Handshake and status decode from the current PC and state.
    always_comb begin
        err_s   = (pc_q[1:0] != 2'b00);
        valid_s = (state_q == S_RUN) & ~stall & ~err_s;
        fire_s  = valid_s & fetch_ready;
        off_s   = CNT_W'((pc_q >> 2) & WORD_MASK);
    end

    assign pc_addr          = pc_q;
    assign addr_err         = err_s;
    assign fetch_valid      = valid_s;
    assign fetch_cnt        = CNT_W'(FETCH_WIDTH) - off_s;
    assign redirect_pending = pend_v_q;

    // Boot sequencer: hold off fetching for BOOT_CYCLES cycles after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    if ((BOOT_CYCLES == 0) || (boot_cnt_q == BOOT_LAST)) begin
                        state_q <= S_RUN;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 4'd1;
                    end
                end
                S_RUN: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q    <= S_BOOT;
                    boot_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    // Next-PC selection. Priority: exception, stalled branch, stall,
    // live branch, pending branch, then advance on an accepted fetch.
    always_comb begin
        pc_d     = pc_q;
        pend_v_d = pend_v_q;
        pend_a_d = pend_a_q;
        if (except) begin
            pc_d     = except_addr;
            pend_v_d = 1'b0;
        end else if (stall) begin
            if (branch) begin
                pend_a_d = branch_addr;
                pend_v_d = 1'b1;
            end else begin
                pend_v_d = pend_v_q;
            end
        end else if (branch) begin
            pc_d     = branch_addr;
            pend_v_d = 1'b0;
        end else if (pend_v_q) begin
            pc_d     = pend_a_q;
            pend_v_d = 1'b0;
        end else if (fire_s) begin
            pc_d     = next_group(pc_q);
        end else begin
            pc_d     = pc_q;
        end
    end

    // PC and pending-redirect registers. Reset discards any latched branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_ADDR;
            pend_v_q <= 1'b0;
            pend_a_q <= {ADDR_W{1'b0}};
        end else begin
            pc_q     <= pc_d;
            pend_v_q <= pend_v_d;
            pend_a_q <= pend_a_d;
        end
    end

endmodule
